dispatch_sequencer: RTL and testbench

//   Drives the 4x4 diagonal dispatcher through one matrix drain: issues diagonals 1..7 on `count`, holds `shouldAdd`
//   for the job, and presents each registered diagonal (d1..d4) to a write-back consumer with a valid/ready handshake.

---
 rtl/dispatch_sequencer_if.sv | 29 ++
 rtl/dispatch_sequencer.sv | 125 ++++++++++++
 tb/tb_dispatch_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_sequencer_if.sv
// Handshake bundle between the drain controller (master) and dispatch_sequencer (slave):
// job start/accumulate, dispatcher count/shouldAdd and the write-back valid/ready channel.
interface dispatch_sequencer_if #(
    parameter int N     = 4,
    parameter int CNT_W = 6,
    parameter int AW    = 4
);
    logic                start;
    logic                accumulate;
    logic                out_ready;
    logic [CNT_W-1:0]    count;
    logic                should_add;
    logic                busy;
    logic                done;
    logic                wb_valid;
    logic [2:0]          wb_diag;
    logic [N-1:0]        wb_lane_mask;
    logic [N*AW-1:0]     wb_addr;

    modport master (
        output start, accumulate, out_ready,
        input  count, should_add, busy, done, wb_valid, wb_diag, wb_lane_mask, wb_addr
    );

    modport slave (
        input  start, accumulate, out_ready,
        output count, should_add, busy, done, wb_valid, wb_diag, wb_lane_mask, wb_addr
    );
endinterface

// File: rtl/dispatch_sequencer.sv
// Sequences one 4x4 diagonal drain: issues diagonals 1..7 to the dispatcher and presents each
// registered diagonal (lane mask + flat addresses) to the write-back consumer via valid/ready.
module dispatch_sequencer #(
    parameter int N     = 4,
    parameter int CNT_W = 6,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dispatch_sequencer_if.slave  bus
);
    localparam logic [2:0] LAST_DIAG = 3'(2 * N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          k_q;
    logic                wb_valid_q;
    logic [2:0]          wb_diag_q;
    logic [N-1:0]        wb_mask_q;
    logic [N*AW-1:0]     wb_addr_q;
    logic                should_add_q;
    logic                busy_q;
    logic                done_q;

    logic                issue;
    logic                wb_fire;
    logic [CNT_W-1:0]    count_o;
    logic [N-1:0]        lane_mask_d;
    logic [N*AW-1:0]     lane_addr_d;

    assign wb_fire = wb_valid_q && bus.out_ready;

    // Lane map for the diagonal about to be issued; it is registered alongside wb_diag.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic          v;
        logic [AW-1:0] a;
        always_comb begin
            v = 1'b0;
            a = '0;
            if (int'(k_q) <= N) begin
                if (gi + 1 <= int'(k_q)) begin
                    v = 1'b1;
                    a = AW'(gi * N + int'(k_q) - gi - 1);
                end
            end else if (gi + 1 <= 2 * N - int'(k_q)) begin
                v = 1'b1;
                a = AW'((int'(k_q) - N + gi) * N + N - gi - 1);
            end
        end
        assign lane_mask_d[gi]           = v;
        assign lane_addr_d[gi*AW +: AW]  = a;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (issue && (k_q == LAST_DIAG)) state_d = S_DRAIN;
            S_DRAIN: if (wb_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // count is combinational so a stalled consumer freezes the dispatcher registers too.
    always_comb begin
        issue   = (state_q == S_RUN) && (!wb_valid_q || bus.out_ready);
        count_o = issue ? CNT_W'(k_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q          <= 3'd0;
            wb_valid_q   <= 1'b0;
            wb_diag_q    <= 3'd0;
            wb_mask_q    <= '0;
            wb_addr_q    <= '0;
            should_add_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == S_IDLE) && bus.start) begin
                should_add_q <= bus.accumulate;
                k_q          <= 3'd1;
                busy_q       <= 1'b1;
            end
            if (issue) begin
                wb_valid_q <= 1'b1;
                wb_diag_q  <= k_q;
                wb_mask_q  <= lane_mask_d;
                wb_addr_q  <= lane_addr_d;
                k_q        <= k_q + 3'd1;
            end else if (wb_fire) begin
                wb_valid_q <= 1'b0;
            end
            if ((state_q == S_DRAIN) && wb_fire) begin
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
                should_add_q <= 1'b0;
            end
        end
    end

    assign bus.count        = count_o;
    assign bus.should_add   = should_add_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_diag      = wb_diag_q;
    assign bus.wb_lane_mask = wb_mask_q;
    assign bus.wb_addr      = wb_addr_q;
endmodule

// File: tb/tb_dispatch_sequencer.sv
// Bench for dispatch_sequencer: directed cycle-exact scenarios plus randomized jobs with random
// back-pressure, checked against a transaction-level model of the drain.
module tb_dispatch_sequencer;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    dispatch_sequencer_if #(.N(4), .CNT_W(6), .AW(4)) bus ();

    dispatch_sequencer #(.N(4), .CNT_W(6), .AW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lanes of diagonal k: every (row,col) with row+col == k+1, in ascending row order.
    function automatic void ref_lanes(input int k, output logic [3:0] mask, output logic [15:0] addr);
        int lane;
        lane = 0;
        mask = '0;
        addr = '0;
        for (int r = 1; r <= 4; r++)
            for (int c = 1; c <= 4; c++)
                if (r + c == k + 1) begin
                    mask[lane]          = 1'b1;
                    addr[lane*4 +: 4]   = 4'((r - 1) * 4 + (c - 1));
                    lane++;
                end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic acc);
        bus.start      = 1'b1;
        bus.accumulate = acc;
        step();
        bus.start      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.accumulate = 1'b0; bus.out_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if ({bus.count, bus.should_add, bus.busy, bus.done, bus.wb_valid, bus.wb_diag,
             bus.wb_lane_mask, bus.wb_addr} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got count=%0d busy=%b valid=%b diag=%0d mask=%b addr=%h want all 0",
                     bus.count, bus.busy, bus.wb_valid, bus.wb_diag, bus.wb_lane_mask, bus.wb_addr);
        end
        step();
        rst_n = 1'b1;
        step();
        $display("reset: outputs checked");
    endtask

    task automatic test_basic(input logic acc);
        logic [3:0]  m;
        logic [15:0] a;
        bus.out_ready = 1'b1;
        do_start(acc);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            checks++;
            if (int'(bus.count) != ((c <= 7) ? c : 0)) begin
                errors++;
                $display("FAIL basic c%0d count: got %0d want %0d", c, bus.count, (c <= 7) ? c : 0);
            end
            checks++;
            if (bus.wb_valid !== (c >= 2 && c <= 8)) begin
                errors++;
                $display("FAIL basic c%0d wb_valid: got %b want %b", c, bus.wb_valid, (c >= 2 && c <= 8));
            end
            if (c >= 2 && c <= 8) begin
                ref_lanes(c - 1, m, a);
                checks++;
                if (int'(bus.wb_diag) != c - 1 || bus.wb_lane_mask !== m || bus.wb_addr !== a) begin
                    errors++;
                    $display("FAIL basic c%0d wb: got diag=%0d mask=%b addr=%h want diag=%0d mask=%b addr=%h",
                             c, bus.wb_diag, bus.wb_lane_mask, bus.wb_addr, c - 1, m, a);
                end
            end
            checks++;
            if (bus.busy !== (c <= 8) || bus.done !== (c == 9) || bus.should_add !== (acc && c <= 8)) begin
                errors++;
                $display("FAIL basic c%0d status: got busy=%b done=%b add=%b want busy=%b done=%b add=%b",
                         c, bus.busy, bus.done, bus.should_add, (c <= 8), (c == 9), (acc && c <= 8));
            end
            step();
        end
        $display("basic: acc=%0b job checked", acc);
    endtask

    task automatic test_stall();
        int          ec, ed;
        logic [3:0]  m;
        logic [15:0] a;
        bus.out_ready = 1'b1;
        do_start(1'b0);
        for (int c = 1; c <= 13; c++) begin
            bus.out_ready = !(c >= 5 && c <= 7);
            @(negedge clk);
            ec = (c <= 4) ? c : (c <= 7) ? 0 : (c <= 10) ? c - 3 : 0;
            ed = (c <= 5) ? c - 1 : (c <= 8) ? 4 : c - 4;
            checks++;
            if (int'(bus.count) != ec) begin
                errors++;
                $display("FAIL stall c%0d count: got %0d want %0d", c, bus.count, ec);
            end
            if (c >= 2 && c <= 11) begin
                ref_lanes(ed, m, a);
                checks++;
                if (!bus.wb_valid || int'(bus.wb_diag) != ed || bus.wb_lane_mask !== m || bus.wb_addr !== a) begin
                    errors++;
                    $display("FAIL stall c%0d wb: got v=%b diag=%0d mask=%b addr=%h want v=1 diag=%0d mask=%b addr=%h",
                             c, bus.wb_valid, bus.wb_diag, bus.wb_lane_mask, bus.wb_addr, ed, m, a);
                end
            end
            checks++;
            if (bus.done !== (c == 12) || bus.busy !== (c <= 11)) begin
                errors++;
                $display("FAIL stall c%0d status: got done=%b busy=%b want done=%b busy=%b",
                         c, bus.done, bus.busy, (c == 12), (c <= 11));
            end
            step();
        end
        bus.out_ready = 1'b1;
        $display("stall: 3-cycle hold at diag 4 checked");
    endtask

    task automatic test_start_ignored();
        int ec;
        bus.out_ready = 1'b1;
        do_start(1'b0);
        for (int c = 1; c <= 19; c++) begin
            bus.start      = (c == 4 || c == 9);
            bus.accumulate = (c == 4 || c == 9);
            @(negedge clk);
            ec = (c <= 7) ? c : (c >= 10 && c <= 16) ? c - 9 : 0;
            checks++;
            if (int'(bus.count) != ec) begin
                errors++;
                $display("FAIL ignore c%0d count: got %0d want %0d", c, bus.count, ec);
            end
            checks++;
            if (bus.done !== (c == 9 || c == 18) || bus.should_add !== (c >= 10 && c <= 17) ||
                bus.busy !== (c <= 8 || (c >= 10 && c <= 17))) begin
                errors++;
                $display("FAIL ignore c%0d status: got done=%b add=%b busy=%b want done=%b add=%b busy=%b",
                         c, bus.done, bus.should_add, bus.busy, (c == 9 || c == 18),
                         (c >= 10 && c <= 17), (c <= 8 || (c >= 10 && c <= 17)));
            end
            step();
        end
        bus.start = 1'b0;
        $display("ignore: mid-job start dropped, start in done cycle accepted");
    endtask

    task automatic test_lane_addr();
        logic [15:0] exp4, exp5;
        exp4 = {4'd12, 4'd9, 4'd6, 4'd3};
        exp5 = {4'd0, 4'd13, 4'd10, 4'd7};
        bus.out_ready = 1'b1;
        do_start(1'b0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 5) begin
                checks++;
                if (bus.wb_diag !== 3'd4 || bus.wb_addr !== exp4 || bus.wb_lane_mask !== 4'b1111) begin
                    errors++;
                    $display("FAIL addr diag4: got diag=%0d addr=%h mask=%b want diag=4 addr=%h mask=1111",
                             bus.wb_diag, bus.wb_addr, bus.wb_lane_mask, exp4);
                end
            end
            if (c == 6) begin
                checks++;
                if (bus.wb_diag !== 3'd5 || bus.wb_addr !== exp5 || bus.wb_lane_mask !== 4'b0111) begin
                    errors++;
                    $display("FAIL addr diag5: got diag=%0d addr=%h mask=%b want diag=5 addr=%h mask=0111",
                             bus.wb_diag, bus.wb_addr, bus.wb_lane_mask, exp5);
                end
            end
            step();
        end
        $display("addr: diag 4 and 5 lane addresses checked");
    endtask

    task automatic test_reset_midjob();
        bool_seen_done: begin end
        bus.out_ready = 1'b1;
        do_start(1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if (bus.wb_diag !== 3'd3 || !bus.wb_valid) begin
                    errors++;
                    $display("FAIL rstmid pre: got diag=%0d valid=%b want diag=3 valid=1", bus.wb_diag, bus.wb_valid);
                end
                rst_n = 1'b0;
            end
            if (c >= 5) begin
                checks++;
                if ({bus.count, bus.should_add, bus.busy, bus.done, bus.wb_valid, bus.wb_diag,
                     bus.wb_lane_mask, bus.wb_addr} !== '0) begin
                    errors++;
                    $display("FAIL rstmid c%0d outputs: got count=%0d busy=%b done=%b valid=%b diag=%0d want all 0",
                             c, bus.count, bus.busy, bus.done, bus.wb_valid, bus.wb_diag);
                end
            end
            step();
            rst_n = 1'b1;
        end
        do_start(1'b1);
        @(negedge clk);
        checks++;
        if (bus.count !== 6'd1 || bus.should_add !== 1'b1) begin
            errors++;
            $display("FAIL rstmid restart: got count=%0d add=%b want count=1 add=1", bus.count, bus.should_add);
        end
        step();
        begin
            int n;
            n = 0;
            while (!bus.done && n < 30) begin
                step();
                n++;
            end
            checks++;
            if (!bus.done) begin
                errors++;
                $display("FAIL rstmid drain: got no done after %0d cycles want done", n);
            end
            step();
        end
        $display("rstmid: job abandoned and restarted");
    endtask

    task automatic test_random(input int jobs);
        for (int j = 0; j < jobs; j++) begin
            logic        acc;
            int          issued, hs, cyc, ec;
            bit          final_prev, final_now, done_seen, exp_valid;
            logic [3:0]  m;
            logic [15:0] a;
            acc = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) step();
            bus.out_ready = 1'($urandom_range(0, 1));
            do_start(acc);
            issued = 0; hs = 0; cyc = 0;
            final_prev = 0; done_seen = 0;
            while (!done_seen && cyc < 100) begin
                bus.out_ready = ($urandom_range(0, 9) < 6);
                @(negedge clk);
                final_now = 0;
                exp_valid = (issued > hs);
                ec = (issued < 7 && (!exp_valid || bus.out_ready)) ? issued + 1 : 0;
                checks++;
                if (int'(bus.count) != ec || bus.wb_valid !== exp_valid) begin
                    errors++;
                    $display("FAIL rand j%0d cyc%0d: got count=%0d valid=%b want count=%0d valid=%b",
                             j, cyc, bus.count, bus.wb_valid, ec, exp_valid);
                end
                if (exp_valid) begin
                    ref_lanes(hs + 1, m, a);
                    checks++;
                    if (int'(bus.wb_diag) != hs + 1 || bus.wb_lane_mask !== m || bus.wb_addr !== a) begin
                        errors++;
                        $display("FAIL rand j%0d cyc%0d wb: got diag=%0d mask=%b addr=%h want diag=%0d mask=%b addr=%h",
                                 j, cyc, bus.wb_diag, bus.wb_lane_mask, bus.wb_addr, hs + 1, m, a);
                    end
                    if (bus.out_ready) begin
                        hs++;
                        final_now = (hs == 7);
                    end
                end
                if (ec != 0) issued++;
                checks++;
                if (bus.done !== final_prev || bus.busy !== !final_prev ||
                    bus.should_add !== (acc && !final_prev)) begin
                    errors++;
                    $display("FAIL rand j%0d cyc%0d status: got done=%b busy=%b add=%b want done=%b busy=%b add=%b",
                             j, cyc, bus.done, bus.busy, bus.should_add, final_prev, !final_prev, acc && !final_prev);
                end
                done_seen  = final_prev;
                final_prev = final_now;
                cyc++;
                step();
            end
            checks++;
            if (!done_seen) begin
                errors++;
                $display("FAIL rand j%0d timeout: got hs=%0d issued=%0d want 7 handshakes and done", j, hs, issued);
            end
            $display("rand: job %0d acc=%0b %0d cycles", j, acc, cyc);
        end
        bus.out_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.accumulate = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_stall();
        test_start_ignored();
        test_lane_addr();
        test_reset_midjob();
        test_random(12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
